// File: rtl/debouncer_pkg.sv
// -----------------------------------------------------------------------------
// debouncer_pkg
// Shared types and constants for the debouncer bank.
//   rpt_state_t    : per-channel auto-repeat FSM state
//   SYNC_RESET_VAL : value loaded into every synchroniser flop on reset
//   max_int()      : elaboration-time helper for sizing shared counters
// Optional feature macro: DEBOUNCER_REPEAT_EN (repeat FSM is only used then).
// -----------------------------------------------------------------------------
package debouncer_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE       = 2'd0,
    RPT_WAIT_DELAY = 2'd1,
    RPT_REPEATING  = 2'd2
  } rpt_state_t;

  localparam logic SYNC_RESET_VAL = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
// One debouncer channel: SYNC_STAGES-deep synchroniser, N-bit stability
// counter, registered clean level, registered rise/fall pulses and a press
// strobe. With DEBOUNCER_REPEAT_EN defined, press also carries auto-repeat
// strobes (first after 2^RPT_DELAY_W cycles, then every 2^RPT_RATE_W cycles);
// otherwise press is a registered copy of rise.
// Ports:
//   i_clk   : clock, all state on posedge
//   i_reset : synchronous active-high reset
//   i_raw   : asynchronous pin level
//   o_clean : debounced level
//   o_rise  : one-cycle pulse after clean goes 0->1
//   o_fall  : one-cycle pulse after clean goes 1->0
//   o_press : rise plus optional auto-repeat strobes
// -----------------------------------------------------------------------------
module debounce_chan
  import debouncer_pkg::*;
#(
  parameter int N           = 20,
  parameter int SYNC_STAGES = 2
`ifdef DEBOUNCER_REPEAT_EN
  ,
  parameter int RPT_DELAY_W = 24,
  parameter int RPT_RATE_W  = 22
`endif
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall,
  output logic o_press
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [N-1:0]           r_cnt;
  logic                   r_clean;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_press;

  logic w_s;
  logic w_differ;
  logic w_toggle;
  logic w_rise_evt;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_differ   = w_s ^ r_clean;
  // Toggle on the edge where the disagreement has already lasted 2^N-1
  // cycles, so the counter never needs to wrap.
  assign w_toggle   = w_differ && (r_cnt == '1);
  assign w_rise_evt = w_toggle && !r_clean;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync  <= {SYNC_STAGES{SYNC_RESET_VAL}};
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      // Any cycle of agreement restarts the stability window.
      if (!w_differ || w_toggle) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + N'(1);
      end
      if (w_toggle) begin
        r_clean <= ~r_clean;
      end
      r_rise <= w_rise_evt;
      r_fall <= w_toggle && r_clean;
    end
  end

`ifdef DEBOUNCER_REPEAT_EN
  localparam int RPT_CNT_W = max_int(RPT_DELAY_W, RPT_RATE_W);
  localparam logic [RPT_CNT_W-1:0] DELAY_LAST = RPT_CNT_W'({RPT_DELAY_W{1'b1}});
  localparam logic [RPT_CNT_W-1:0] RATE_LAST  = RPT_CNT_W'({RPT_RATE_W{1'b1}});

  rpt_state_t           r_state;
  logic [RPT_CNT_W-1:0] r_rcnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= RPT_IDLE;
      r_rcnt  <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (w_rise_evt) begin
        r_state <= RPT_WAIT_DELAY;
        r_rcnt  <= '0;
        r_press <= 1'b1;
      end else if (w_toggle || !r_clean) begin
        // Remaining toggles are falls: release wins over a due repeat strobe.
        r_state <= RPT_IDLE;
        r_rcnt  <= '0;
      end else begin
        case (r_state)
          RPT_WAIT_DELAY: begin
            if (r_rcnt == DELAY_LAST) begin
              r_press <= 1'b1;
              r_rcnt  <= '0;
              r_state <= RPT_REPEATING;
            end else begin
              r_rcnt <= r_rcnt + RPT_CNT_W'(1);
            end
          end
          RPT_REPEATING: begin
            if (r_rcnt == RATE_LAST) begin
              r_press <= 1'b1;
              r_rcnt  <= '0;
            end else begin
              r_rcnt <= r_rcnt + RPT_CNT_W'(1);
            end
          end
          default: begin
            r_state <= RPT_IDLE;
            r_rcnt  <= '0;
          end
        endcase
      end
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_press <= 1'b0;
    end else begin
      r_press <= w_rise_evt;
    end
  end
`endif

  assign o_clean = r_clean;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_press = r_press;

endmodule

// File: rtl/debouncer_bank.sv
// -----------------------------------------------------------------------------
// debouncer_bank
// CHANNELS independent debouncers for pushbuttons and switches. Each raw pin
// is synchronised, debounced by a 2^N-cycle stability window, and produces a
// clean level, rise/fall pulses and a press strobe.
// Optional feature macro: DEBOUNCER_REPEAT_EN adds auto-repeat to press.
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous active-high reset
//   raw   : [CHANNELS] asynchronous pin levels
//   clean : [CHANNELS] debounced levels
//   rise  : [CHANNELS] one-cycle pulses on clean 0->1
//   fall  : [CHANNELS] one-cycle pulses on clean 1->0
//   press : [CHANNELS] rise plus auto-repeat strobes (== rise without macro)
// -----------------------------------------------------------------------------
module debouncer_bank
  import debouncer_pkg::*;
#(
  parameter int CHANNELS    = 5,
  parameter int N           = 20,
  parameter int SYNC_STAGES = 2,
  parameter int RPT_DELAY_W = 24,
  parameter int RPT_RATE_W  = 22
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] press
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || N < 1 ||
      RPT_DELAY_W < 1 || RPT_RATE_W < 1 || CHANNELS < 1) begin : g_param_check
    $error("debouncer_bank: illegal parameter combination");
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    debounce_chan #(
      .N           (N),
      .SYNC_STAGES (SYNC_STAGES)
`ifdef DEBOUNCER_REPEAT_EN
      ,
      .RPT_DELAY_W (RPT_DELAY_W),
      .RPT_RATE_W  (RPT_RATE_W)
`endif
    ) u_chan (
      .i_clk   (clk),
      .i_reset (reset),
      .i_raw   (raw[gi]),
      .o_clean (clean[gi]),
      .o_rise  (rise[gi]),
      .o_fall  (fall[gi]),
      .o_press (press[gi])
    );
  end

endmodule

// File: tb/tb_debouncer_bank.sv
module tb_debouncer_bank;

  localparam int CH     = 5;
  localparam int N      = 3;
  localparam int SYNC   = 2;
  localparam int RDW    = 4;
  localparam int RRW    = 2;
  localparam int STAB   = 1 << N;
  localparam int RDELAY = 1 << RDW;
  localparam int RRATE  = 1 << RRW;

  typedef struct packed {
    logic [CH-1:0] clean;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] press;
  } exp_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] raw   = '0;
  logic [CH-1:0] clean;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] press;

  always #5 clk = ~clk;

  debouncer_bank #(
    .CHANNELS    (CH),
    .N           (N),
    .SYNC_STAGES (SYNC),
    .RPT_DELAY_W (RDW),
    .RPT_RATE_W  (RRW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .raw   (raw),
    .clean (clean),
    .rise  (rise),
    .fall  (fall),
    .press (press)
  );

  // Scoreboard and reference-model state
  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  bit   m_pipe[CH][$];   // raw samples still travelling through the synchroniser
  bit   m_clean[CH];
  int   m_streak[CH];    // consecutive edges the synchronised input disagreed
  int   m_held[CH];      // edges since the last rise while clean stays high

  task automatic cmp(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %b required %b", name, cyc, act, exp);
    end
  endtask

  // Expected outputs visible after one posedge, given the inputs it samples.
  task automatic model_edge(input logic [CH-1:0] r, input logic rst, output exp_t e);
    bit s;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        m_pipe[c].delete();
        for (int k = 0; k < SYNC; k++) m_pipe[c].push_back(1'b0);
        m_clean[c]  = 1'b0;
        m_streak[c] = 0;
        m_held[c]   = 0;
      end else begin
        s = m_pipe[c].pop_front();
        m_pipe[c].push_back(r[c]);
        if (s != m_clean[c]) begin
          m_streak[c]++;
          if (m_streak[c] == STAB) begin
            m_clean[c]  = s;
            m_streak[c] = 0;
            if (s) e.rise[c] = 1'b1;
            else   e.fall[c] = 1'b1;
          end
        end else begin
          m_streak[c] = 0;
        end
`ifdef DEBOUNCER_REPEAT_EN
        if (e.rise[c]) begin
          m_held[c]  = 0;
          e.press[c] = 1'b1;
        end else if (m_clean[c]) begin
          m_held[c]++;
          e.press[c] = (m_held[c] == RDELAY) ||
                       (m_held[c] > RDELAY && ((m_held[c] - RDELAY) % RRATE) == 0);
        end
`else
        e.press[c] = e.rise[c];
`endif
      end
      e.clean[c] = m_clean[c];
    end
  endtask

  task automatic step(input logic [CH-1:0] r, input logic rst);
    exp_t e;
    @(negedge clk);
    raw   = r;
    reset = rst;
    model_edge(r, rst, e);
    sb.push_back(e);
  endtask

  task automatic hold(input logic [CH-1:0] r, input int n);
    for (int i = 0; i < n; i++) step(r, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a new output set.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      cmp("clean", clean, mon_e.clean);
      cmp("rise",  rise,  mon_e.rise);
      cmp("fall",  fall,  mon_e.fall);
      cmp("press", press, mon_e.press);
    end
  end

  initial begin
    logic [CH-1:0] cur;
    logic [CH-1:0] v;

    step('0, 1'b1);
    step('0, 1'b1);
    hold('0, 4);

    // Stable press on channel 0
    hold(5'b00001, 14);
    // Glitchy channel 1 (5 high / 1 low) while channel 0 stays pressed
    for (int g = 0; g < 4; g++) begin
      hold(5'b00011, 5);
      hold(5'b00001, 1);
    end
    // Release channel 0
    hold(5'b00000, 14);
    // Reset in the middle of channel 2's window
    hold(5'b00100, 5);
    step(5'b00100, 1'b1);
    hold(5'b00100, 14);
    // Simultaneous rises on channels 3 and 4
    hold(5'b11100, 14);
    hold(5'b00000, 12);
    // Long hold for auto-repeat, then release
    hold(5'b00001, 40);
    hold(5'b00000, 14);

    // Randomised traffic with glitches and occasional resets
    cur = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(11) == 0) cur[c] = ~cur[c];
      v = cur;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(29) == 0) v[c] = ~v[c];
      step(v, ($urandom_range(249) == 0));
    end
    hold(cur, 12);

    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain cycle %0d actual %0d pending required 0", cyc, sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
